// File: rtl/sum_checker_pkg.sv
// Shared state encodings, limits and helpers for the sum_checker result monitor.
package sum_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int unsigned MAX_LATENCY = 8;
    localparam int unsigned SAT_W       = 32;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned      width);
        logic [SAT_W-1:0] max_v;
        max_v = (SAT_W'(1) << width) - SAT_W'(1);
        return (value >= max_v) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/sum_checker_pipe.sv
// Delay line carrying {valid, expected} from operand sample to result compare.
module sum_checker_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Flush only drops valid bits; stale data behind a cleared valid is harmless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i && !flush_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1] && !flush_i;
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sum_checker.sv
// Registered-adder result checker: recompute, delay, compare, count, capture first error.
// Optional SUM_CHECKER_DISPLAY_EN adds a simulation-only message per mismatch.
module sum_checker
    import sum_checker_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 halt_on_error,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     out,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic                 error,
    output logic [WIDTH-1:0]     first_err_expected,
    output logic [WIDTH-1:0]     first_err_observed,
    output logic                 halted
);

    // Out-of-range latencies are clamped into the supported 1..MAX_LATENCY window.
    localparam int unsigned PIPE_DEPTH = (LATENCY < 1) ? 1 :
                                         (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] match_cnt_q;
    logic [CNT_WIDTH-1:0] error_cnt_q;
    logic                 error_q;
    logic [WIDTH-1:0]     first_exp_q;
    logic [WIDTH-1:0]     first_obs_q;
    logic                 halted_q;

    logic [WIDTH-1:0]     exp_sum;
    logic                 load_en;
    logic                 pipe_valid;
    logic [WIDTH-1:0]     pipe_exp;
    logic                 do_cmp;
    logic                 mismatch;

    assign exp_sum  = in0 + in1;
    assign load_en  = enable && in_valid && (state_q == ST_RUN);
    // Dropping enable or a same-cycle clear both suppress the due comparison.
    assign do_cmp   = pipe_valid && (state_q == ST_RUN) && enable && !clear;
    assign mismatch = do_cmp && (pipe_exp != out);

    sum_checker_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (PIPE_DEPTH)
    ) u_pipe (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (!enable),
        .valid_i (load_en),
        .data_i  (exp_sum),
        .valid_o (pipe_valid),
        .data_o  (pipe_exp)
    );

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  if (mismatch && halt_on_error) state_d = ST_HALT;
                ST_HALT: if (clear) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            halted_q    <= 1'b0;
            match_cnt_q <= '0;
            error_cnt_q <= '0;
            error_q     <= 1'b0;
            first_exp_q <= '0;
            first_obs_q <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
            if (clear) begin
                match_cnt_q <= '0;
                error_cnt_q <= '0;
                error_q     <= 1'b0;
                first_exp_q <= '0;
                first_obs_q <= '0;
            end else if (do_cmp) begin
                if (mismatch) begin
                    error_cnt_q <= CNT_WIDTH'(sat_inc(SAT_W'(error_cnt_q), CNT_WIDTH));
                    error_q     <= 1'b1;
                    if (!error_q) begin
                        first_exp_q <= pipe_exp;
                        first_obs_q <= out;
                    end
                end else begin
                    match_cnt_q <= CNT_WIDTH'(sat_inc(SAT_W'(match_cnt_q), CNT_WIDTH));
                end
            end
        end
    end

`ifdef SUM_CHECKER_DISPLAY_EN
    always @(posedge clock) begin
        if (!reset && mismatch) begin
            $display("sum_checker: expected %0d observed %0d", pipe_exp, out);
        end
    end
`endif

    assign match_count        = match_cnt_q;
    assign error_count        = error_cnt_q;
    assign error              = error_q;
    assign first_err_expected = first_exp_q;
    assign first_err_observed = first_obs_q;
    assign halted             = halted_q;

endmodule

// File: tb/tb_sum_checker.sv
// Self-checking bench for sum_checker: table vectors with a count scoreboard plus corner sequences.
module tb_sum_checker;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Main instance: WIDTH=8, LATENCY=1, CNT_WIDTH=16
    logic        enable, clear, halt_on_error, in_valid;
    logic [7:0]  in0, in1, out;
    logic [15:0] match_count, error_count;
    logic        error, halted;
    logic [7:0]  fe, fo;

    // Saturation instance: WIDTH=8, LATENCY=3, CNT_WIDTH=4
    logic        s_enable, s_clear, s_halt, s_valid;
    logic [7:0]  s_in0, s_in1, s_out;
    logic [3:0]  s_match, s_err;
    logic        s_error, s_halted;
    logic [7:0]  s_fe, s_fo;

    sum_checker #(.WIDTH(8), .LATENCY(1), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .halt_on_error(halt_on_error), .in_valid(in_valid), .in0(in0), .in1(in1), .out(out),
        .match_count(match_count), .error_count(error_count), .error(error),
        .first_err_expected(fe), .first_err_observed(fo), .halted(halted)
    );

    sum_checker #(.WIDTH(8), .LATENCY(3), .CNT_WIDTH(4)) dut_sat (
        .clock(clock), .reset(reset), .enable(s_enable), .clear(s_clear),
        .halt_on_error(s_halt), .in_valid(s_valid), .in0(s_in0), .in1(s_in1), .out(s_out),
        .match_count(s_match), .error_count(s_err), .error(s_error),
        .first_err_expected(s_fe), .first_err_observed(s_fo), .halted(s_halted)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] obs;
        logic       match;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] m;
        logic [15:0] e;
    } sb_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    sb_t  sbq  [$];
    sb_t  ssbq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and retire any scoreboard entries now due.
    task automatic tick();
        sb_t t;
        @(negedge clock);
        cyc++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            t = sbq.pop_front();
            chk("match_count", 32'(match_count), 32'(t.m));
            chk("error_count", 32'(error_count), 32'(t.e));
        end
        while (ssbq.size() > 0 && ssbq[0].due <= cyc) begin
            t = ssbq.pop_front();
            chk("sat_match_count", 32'(s_match), 32'(t.m));
            chk("sat_error_count", 32'(s_err), 32'(t.e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] em, ee;
        logic [7:0]  sums [20];
        int          seen;

        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{a: 8'(i + 1), b: 8'(i + 2), obs: 8'(2 * i + 3), match: 1'b1};
        end
        vecs[10] = '{a: 8'd200, b: 8'd100, obs: 8'd44, match: 1'b1};
        vecs[11] = '{a: 8'd200, b: 8'd100, obs: 8'(16'd300), match: 1'b1};
        vecs[12] = '{a: 8'd2,   b: 8'd3,   obs: 8'd0,  match: 1'b0};
        vecs[13] = '{a: 8'd4,   b: 8'd5,   obs: 8'd1,  match: 1'b0};
        vecs[14] = '{a: 8'd7,   b: 8'd7,   obs: 8'd14, match: 1'b1};

        reset = 1'b1;
        enable = 0; clear = 0; halt_on_error = 0; in_valid = 0; in0 = 0; in1 = 0; out = 0;
        s_enable = 0; s_clear = 0; s_halt = 0; s_valid = 0; s_in0 = 0; s_in1 = 0; s_out = 0;
        repeat (2) @(negedge clock);
        chk("reset_match", 32'(match_count), 0);
        chk("reset_errcnt", 32'(error_count), 0);
        chk("reset_error", 32'(error), 0);
        chk("reset_fe", 32'(fe), 0);
        chk("reset_fo", 32'(fo), 0);
        chk("reset_halted", 32'(halted), 0);
        reset = 1'b0;

        // Table vectors, LATENCY=1: out for vector k is presented one cycle after its operands
        enable = 1'b1;
        tick();
        em = 0; ee = 0;
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                in_valid = 1'b1; in0 = vecs[k].a; in1 = vecs[k].b;
                if (vecs[k].match) em++; else ee++;
                sbq.push_back('{due: cyc + 2, m: em, e: ee});
            end else begin
                in_valid = 1'b0;
            end
            if (k > 0) out = vecs[k-1].obs;
            tick();
        end
        chk("error_sticky", 32'(error), 1);
        chk("first_err_expected", 32'(fe), 5);
        chk("first_err_observed", 32'(fo), 0);
        chk("no_halt_when_disabled", 32'(halted), 0);

        // Halt on first mismatch, then clear resumes
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_match", 32'(match_count), 0);
        chk("clear_errcnt", 32'(error_count), 0);
        chk("clear_error", 32'(error), 0);
        chk("clear_fe", 32'(fe), 0);
        halt_on_error = 1'b1;
        in0 = 8'd10; in1 = 8'd10; in_valid = 1'b1; tick();
        in_valid = 1'b0; out = 8'd0; tick();
        chk("halt_halted", 32'(halted), 1);
        chk("halt_errcnt", 32'(error_count), 1);
        chk("halt_fe", 32'(fe), 20);
        for (int i = 0; i < 5; i++) begin
            in0 = 8'(i); in1 = 8'd1; in_valid = 1'b1; out = 8'd99; tick();
            chk("halt_frozen_err", 32'(error_count), 1);
            chk("halt_frozen_match", 32'(match_count), 0);
            chk("halt_held", 32'(halted), 1);
        end
        in_valid = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        chk("resume_halted", 32'(halted), 0);
        chk("resume_errcnt", 32'(error_count), 0);
        chk("resume_error", 32'(error), 0);
        in0 = 8'd3; in1 = 8'd4; in_valid = 1'b1; tick();
        in_valid = 1'b0; out = 8'd7; tick();
        chk("resume_match", 32'(match_count), 1);
        chk("resume_errcnt2", 32'(error_count), 0);
        halt_on_error = 1'b0;

        // Enable drop with a transaction in flight drops its comparison
        in0 = 8'd1; in1 = 8'd1; in_valid = 1'b1; tick();
        in_valid = 1'b0; enable = 1'b0; out = 8'd2; tick();
        chk("endrop_match", 32'(match_count), 1);
        enable = 1'b1; tick(); tick();
        chk("endrop_match2", 32'(match_count), 1);
        chk("endrop_errcnt", 32'(error_count), 0);
        in0 = 8'd5; in1 = 8'd6; in_valid = 1'b1; tick();
        in_valid = 1'b0; out = 8'd11; tick();
        chk("endrop_resume", 32'(match_count), 2);

        // Clear wins over a same-cycle comparison
        in0 = 8'd2; in1 = 8'd2; in_valid = 1'b1; tick();
        in_valid = 1'b0; out = 8'd4; clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_wins_match", 32'(match_count), 0);
        tick();
        chk("clear_wins_after", 32'(match_count), 0);

        // Seven matches, then asynchronous reset mid-run
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) begin in0 = 8'(k); in1 = 8'(k); in_valid = 1'b1; end
            else in_valid = 1'b0;
            if (k > 0) out = 8'(2 * (k - 1));
            tick();
        end
        chk("prereset_match", 32'(match_count), 7);
        in0 = 8'd9; in1 = 8'd9; in_valid = 1'b1; tick();
        in_valid = 1'b0; out = 8'd18;
        #1 reset = 1'b1;
        #1;
        chk("async_rst_match", 32'(match_count), 0);
        chk("async_rst_errcnt", 32'(error_count), 0);
        chk("async_rst_error", 32'(error), 0);
        chk("async_rst_halted", 32'(halted), 0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_match", 32'(match_count), 0);
        chk("post_rst_errcnt", 32'(error_count), 0);

        // Saturation and exact latency, LATENCY=3, CNT_WIDTH=4
        s_enable = 1'b1;
        tick();
        for (int k = 0; k <= 22; k++) begin
            if (k < 20) begin
                s_in0 = 8'(3 * k); s_in1 = 8'(k + 1); s_valid = 1'b1;
                sums[k] = 8'(4 * k + 1);
            end else begin
                s_valid = 1'b0;
            end
            if (k >= 3) s_out = sums[k-3];
            seen = (k < 3) ? 0 : (k - 2);
            if (seen > 15) seen = 15;
            ssbq.push_back('{due: cyc + 1, m: 16'(seen), e: 16'd0});
            tick();
        end
        chk("sat_error", 32'(s_error), 0);
        chk("sb_drained", 32'(sbq.size() + ssbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
